// File: rtl/note_sequencer.sv
// note_sequencer
//   Plays a programmable note table through the tone generator. Each table
//   entry holds a duration in 48 kHz ticks, a wave select and a frequency.
//   Notes and the silent gap after each one are timed with the generator's
//   sample strobe. The block runs in the 48 MHz domain.
//
// Ports
//   i_clk48    48 MHz clock
//   i_rst48    synchronous reset, active-high
//   i_tick     48 kHz strobe from the generator, one clock wide
//   i_wr_en    note-table write strobe
//   i_wr_addr  note-table write address
//   i_wr_data  {dur[41:26], wave[25:24], freq[23:0]}
//   i_len      number of entries to play (1..DEPTH), latched on start
//   i_start    start strobe, honoured only while idle
//   i_stop     abort strobe
//   i_loop     wrap to entry 0 after the last entry
//   o_targetf  frequency to the generator
//   o_wave     {6'b0, wave} to the generator
//   o_pause    pause to the generator
//   o_busy     high whenever a sequence is active
//   o_idx      entry currently fetched or playing
//   o_done     one-cycle pulse at the end of a non-looping sequence
module note_sequencer #(
  parameter int DEPTH     = 16,
  parameter int GAP_TICKS = 48,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          i_clk48,
  input  logic          i_rst48,
  input  logic          i_tick,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [41:0]   i_wr_data,
  input  logic [AW:0]   i_len,
  input  logic          i_start,
  input  logic          i_stop,
  input  logic          i_loop,
  output logic [23:0]   o_targetf,
  output logic [7:0]    o_wave,
  output logic          o_pause,
  output logic          o_busy,
  output logic [AW-1:0] o_idx,
  output logic          o_done
);

  // The gap counter keeps at least one bit so GAP_TICKS = 0 still elaborates.
  localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  // A fetch spans three cycles: the table address register loads o_idx, the
  // table output register loads the entry, then the entry is decoded. This
  // puts the first unpaused note three edges after the start edge.
  typedef enum logic [2:0] {
    IDLE,
    FETCH_ADDR,
    FETCH_READ,
    FETCH_DATA,
    PLAY,
    GAP
  } state_t;

  state_t        state_q, state_n;
  logic [AW-1:0] idx_q, idx_n;
  logic [AW:0]   len_q, len_n;
  logic [15:0]   cnt_q, cnt_n;
  logic [GW-1:0] gcnt_q, gcnt_n;
  logic [23:0]   targetf_q, targetf_n;
  logic [1:0]    wave_q, wave_n;
  logic          pause_q, pause_n;
  logic          done_q, done_n;
  logic          busy_q;
  logic          advance;
  logic          len_ok;

  logic [41:0]   table_mem [DEPTH];
  logic [AW-1:0] rd_addr_q;
  logic [41:0]   rd_data_q;

  logic [15:0]   rd_dur;
  logic [1:0]    rd_wave;
  logic [23:0]   rd_freq;

  assign rd_dur  = rd_data_q[41:26];
  assign rd_wave = rd_data_q[25:24];
  assign rd_freq = rd_data_q[23:0];

  // Table storage is deliberately left out of reset. Reading in the same
  // block as the write makes a same-address read return the old entry.
  always_ff @(posedge i_clk48) begin
    if (i_wr_en) begin
      table_mem[i_wr_addr] <= i_wr_data;
    end
    rd_data_q <= table_mem[rd_addr_q];
  end

  assign len_ok = (i_len != '0) && (i_len <= (AW+1)'(DEPTH));

  always_comb begin
    state_n   = state_q;
    idx_n     = idx_q;
    len_n     = len_q;
    cnt_n     = cnt_q;
    gcnt_n    = gcnt_q;
    targetf_n = targetf_q;
    wave_n    = wave_q;
    pause_n   = pause_q;
    done_n    = 1'b0;
    advance   = 1'b0;

    if ((state_q != IDLE) && i_stop) begin
      state_n = IDLE;
      pause_n = 1'b1;
      idx_n   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start && !i_stop && len_ok) begin
            len_n   = i_len;
            idx_n   = '0;
            state_n = FETCH_ADDR;
          end
        end
        FETCH_ADDR: state_n = FETCH_READ;
        FETCH_READ: state_n = FETCH_DATA;
        FETCH_DATA: begin
          // A zero-length entry is skipped without touching the generator.
          if (rd_dur != '0) begin
            targetf_n = rd_freq;
            wave_n    = rd_wave;
            pause_n   = 1'b0;
            cnt_n     = rd_dur;
            state_n   = PLAY;
          end else begin
            advance = 1'b1;
          end
        end
        PLAY: begin
          if (i_tick) begin
            if (cnt_q > 16'd1) begin
              cnt_n = cnt_q - 16'd1;
            end else begin
              cnt_n = '0;
              if (GAP_TICKS > 0) begin
                pause_n = 1'b1;
                gcnt_n  = GW'(GAP_TICKS);
                state_n = GAP;
              end else begin
                advance = 1'b1;
              end
            end
          end
        end
        GAP: begin
          if (i_tick) begin
            if (gcnt_q > GW'(1)) begin
              gcnt_n = gcnt_q - GW'(1);
            end else begin
              gcnt_n  = '0;
              advance = 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase

      if (advance) begin
        if (((AW+1)'(idx_q) + (AW+1)'(1)) < len_q) begin
          idx_n   = idx_q + AW'(1);
          state_n = FETCH_ADDR;
        end else if (i_loop) begin
          idx_n   = '0;
          state_n = FETCH_ADDR;
        end else begin
          idx_n   = '0;
          pause_n = 1'b1;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
    end
  end

  always_ff @(posedge i_clk48) begin
    if (i_rst48) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      gcnt_q    <= '0;
      targetf_q <= '0;
      wave_q    <= '0;
      pause_q   <= 1'b1;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_n;
      idx_q     <= idx_n;
      len_q     <= len_n;
      cnt_q     <= cnt_n;
      gcnt_q    <= gcnt_n;
      targetf_q <= targetf_n;
      wave_q    <= wave_n;
      pause_q   <= pause_n;
      done_q    <= done_n;
      busy_q    <= (state_n != IDLE);
      rd_addr_q <= idx_q;
    end
  end

  assign o_targetf = targetf_q;
  assign o_wave    = {6'b0, wave_q};
  assign o_pause   = pause_q;
  assign o_busy    = busy_q;
  assign o_idx     = idx_q;
  assign o_done    = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer
//   Directed bench for note_sequencer with DEPTH=16 and a two-tick gap.
//   The 48 kHz strobe is scaled down to one tick every TICK_PERIOD clocks.
module tb_note_sequencer;

  localparam int DEPTH       = 16;
  localparam int AW          = 4;
  localparam int GAP         = 2;
  localparam int TICK_PERIOD = 40;

  logic          i_clk48 = 1'b0;
  logic          i_rst48 = 1'b1;
  logic          i_tick = 1'b0;
  logic          i_wr_en = 1'b0;
  logic [AW-1:0] i_wr_addr = '0;
  logic [41:0]   i_wr_data = '0;
  logic [AW:0]   i_len = '0;
  logic          i_start = 1'b0;
  logic          i_stop = 1'b0;
  logic          i_loop = 1'b0;
  logic [23:0]   o_targetf;
  logic [7:0]    o_wave;
  logic          o_pause;
  logic          o_busy;
  logic [AW-1:0] o_idx;
  logic          o_done;

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  int tick_ctr = 0;
  bit tick_en = 1'b0;

  note_sequencer #(.DEPTH(DEPTH), .GAP_TICKS(GAP)) dut (
    .i_clk48   (i_clk48),
    .i_rst48   (i_rst48),
    .i_tick    (i_tick),
    .i_wr_en   (i_wr_en),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .i_len     (i_len),
    .i_start   (i_start),
    .i_stop    (i_stop),
    .i_loop    (i_loop),
    .o_targetf (o_targetf),
    .o_wave    (o_wave),
    .o_pause   (o_pause),
    .o_busy    (o_busy),
    .o_idx     (o_idx),
    .o_done    (o_done)
  );

  always #5 i_clk48 = ~i_clk48;

  // Advances one clock, samples just after the edge and schedules the
  // tick strobe for the coming cycle.
  task automatic step();
    @(posedge i_clk48);
    #1;
    if (o_done) done_count++;
    if (tick_en) begin
      tick_ctr++;
      if (tick_ctr >= TICK_PERIOD) begin
        tick_ctr = 0;
        i_tick = 1'b1;
      end else begin
        i_tick = 1'b0;
      end
    end else begin
      i_tick = 1'b0;
    end
  endtask

  task automatic write_entry(input int addr, input logic [15:0] dur,
                             input logic [1:0] wave, input logic [23:0] freq);
    i_wr_en   = 1'b1;
    i_wr_addr = addr[AW-1:0];
    i_wr_data = {dur, wave, freq};
    step();
    i_wr_en   = 1'b0;
  endtask

  task automatic start_seq(input int len, input logic loop);
    i_len    = len[AW:0];
    i_loop   = loop;
    i_start  = 1'b1;
    tick_ctr = 0;
    tick_en  = 1'b1;
    step();
    i_start  = 1'b0;
  endtask

  task automatic stop_seq();
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
  endtask

  // Steps until entry 'want' is audibly playing, within a cycle budget.
  task automatic wait_play(input logic [AW-1:0] want, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (o_busy && !o_pause && o_idx == want) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    i_rst48 = 1'b1;
    repeat (3) step();
    checks++;
    if ({o_pause, o_busy, o_done} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 100", {o_pause, o_busy, o_done});
    end
    checks++;
    if ({o_targetf, o_wave, o_idx} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_values: got targetf=%0d wave=%0d idx=%0d expected zeros",
               o_targetf, o_wave, o_idx);
    end
    i_rst48 = 1'b0;
    step();
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle: got busy=%b expected 0", o_busy);
    end
  endtask

  task automatic test_play();
    logic [26:0] obs [32];
    logic [26:0] expv [32];
    int n_obs;
    int n_exp;
    int durs [3] = '{4, 2, 3};
    logic [1:0] waves [3] = '{2'd0, 2'd1, 2'd3};
    logic [23:0] freqs [3] = '{24'd440, 24'd880, 24'd220};

    n_exp = 0;
    for (int e = 0; e < 3; e++) begin
      for (int t = 0; t < durs[e]; t++) begin
        expv[n_exp] = {1'b0, waves[e], freqs[e]};
        n_exp++;
      end
      for (int t = 0; t < GAP; t++) begin
        expv[n_exp] = {1'b1, waves[e], freqs[e]};
        n_exp++;
      end
    end

    done_count = 0;
    start_seq(3, 1'b0);
    checks++;
    if ({o_busy, o_pause} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL play_start_edge: got busy,pause=%b expected 11", {o_busy, o_pause});
    end
    step();
    checks++;
    if (o_pause !== 1'b1) begin
      errors++;
      $display("[TB] FAIL play_latency_early: got pause=%b expected 1", o_pause);
    end
    step();
    step();
    checks++;
    if ({o_pause, o_targetf, o_wave} !== {1'b0, 24'd440, 8'd0}) begin
      errors++;
      $display("[TB] FAIL play_latency: got pause=%b f=%0d w=%0d expected 0/440/0",
               o_pause, o_targetf, o_wave);
    end

    n_obs = 0;
    for (int c = 0; c < 5000 && done_count == 0; c++) begin
      if (i_tick) begin
        if (n_obs < 32) obs[n_obs] = {o_pause, o_wave[1:0], o_targetf};
        n_obs++;
      end
      step();
    end
    checks++;
    if (n_obs != n_exp) begin
      errors++;
      $display("[TB] FAIL play_tick_count: got %0d expected %0d", n_obs, n_exp);
    end
    for (int k = 0; k < n_exp && k < n_obs; k++) begin
      checks++;
      if (obs[k] !== expv[k]) begin
        errors++;
        $display("[TB] FAIL play_tick%0d: got pause=%b w=%0d f=%0d expected pause=%b w=%0d f=%0d",
                 k, obs[k][26], obs[k][25:24], obs[k][23:0],
                 expv[k][26], expv[k][25:24], expv[k][23:0]);
      end
    end
    repeat (5) step();
    checks++;
    if (done_count != 1) begin
      errors++;
      $display("[TB] FAIL play_done_count: got %0d expected 1", done_count);
    end
    checks++;
    if ({o_busy, o_pause, o_idx} !== {1'b0, 1'b1, 4'd0}) begin
      errors++;
      $display("[TB] FAIL play_end_idle: got busy=%b pause=%b idx=%0d expected 0/1/0",
               o_busy, o_pause, o_idx);
    end
    tick_en = 1'b0;
  endtask

  task automatic test_loop();
    logic [AW-1:0] seq [4];
    logic [AW-1:0] prev;
    int nseq;
    int ticks;
    bit ok;

    done_count = 0;
    start_seq(2, 1'b1);
    prev = o_idx;
    nseq = 0;
    for (int c = 0; c < 6000 && nseq < 4; c++) begin
      step();
      if (o_idx !== prev) begin
        seq[nseq] = o_idx;
        nseq++;
        prev = o_idx;
      end
    end
    checks++;
    if (nseq != 4 || {seq[0], seq[1], seq[2], seq[3]} !== {4'd1, 4'd0, 4'd1, 4'd0}) begin
      errors++;
      $display("[TB] FAIL loop_idx_seq: got %0d transitions %0d,%0d,%0d,%0d expected 1,0,1,0",
               nseq, seq[0], seq[1], seq[2], seq[3]);
    end
    checks++;
    if (done_count != 0) begin
      errors++;
      $display("[TB] FAIL loop_no_done: got %0d expected 0", done_count);
    end

    wait_play(4'd1, ok);
    write_entry(0, 16'd4, 2'd0, 24'd1000);
    wait_play(4'd0, ok);
    checks++;
    if (!ok || o_targetf !== 24'd1000) begin
      errors++;
      $display("[TB] FAIL live_write: got f=%0d reached=%0d expected 1000", o_targetf, ok);
    end

    wait_play(4'd1, ok);
    i_loop = 1'b0;
    ticks = 0;
    for (int c = 0; c < 4000 && done_count == 0; c++) begin
      if (i_tick) ticks++;
      step();
    end
    checks++;
    if (ticks != 2 + GAP) begin
      errors++;
      $display("[TB] FAIL loop_drop_ticks: got %0d expected %0d", ticks, 2 + GAP);
    end
    checks++;
    if (done_count != 1 || o_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL loop_drop_done: got done=%0d busy=%b expected 1/0", done_count, o_busy);
    end
    tick_en = 1'b0;
  endtask

  task automatic test_stop();
    bit ok;
    int done_before;

    done_count = 0;
    start_seq(3, 1'b0);
    wait_play(4'd1, ok);
    stop_seq();
    checks++;
    if (!ok || {o_pause, o_busy, o_idx} !== {1'b1, 1'b0, 4'd0}) begin
      errors++;
      $display("[TB] FAIL stop_state: got pause=%b busy=%b idx=%0d reached=%0d expected 1/0/0",
               o_pause, o_busy, o_idx, ok);
    end
    checks++;
    if ({o_targetf, o_wave} !== {24'd880, 8'd1}) begin
      errors++;
      $display("[TB] FAIL stop_hold: got f=%0d w=%0d expected 880/1", o_targetf, o_wave);
    end
    done_before = done_count;
    repeat (100) step();
    checks++;
    if (done_count != done_before || done_before != 0) begin
      errors++;
      $display("[TB] FAIL stop_no_done: got %0d expected 0", done_count);
    end

    start_seq(3, 1'b0);
    repeat (3) step();
    checks++;
    if ({o_pause, o_idx, o_targetf} !== {1'b0, 4'd0, 24'd1000}) begin
      errors++;
      $display("[TB] FAIL stop_restart: got pause=%b idx=%0d f=%0d expected 0/0/1000",
               o_pause, o_idx, o_targetf);
    end
    stop_seq();
    tick_en = 1'b0;
  endtask

  task automatic test_edges();
    int n_obs;
    bit seen_skip;

    write_entry(1, 16'd0, 2'd2, 24'd5000);
    done_count = 0;
    seen_skip = 1'b0;
    start_seq(3, 1'b0);
    n_obs = 0;
    for (int c = 0; c < 5000 && done_count == 0; c++) begin
      if (i_tick) n_obs++;
      if (o_targetf == 24'd5000 || (o_idx == 4'd1 && !o_pause)) seen_skip = 1'b1;
      step();
    end
    checks++;
    if (n_obs != 4 + GAP + 3 + GAP) begin
      errors++;
      $display("[TB] FAIL skip_ticks: got %0d expected %0d", n_obs, 4 + GAP + 3 + GAP);
    end
    checks++;
    if (seen_skip) begin
      errors++;
      $display("[TB] FAIL skip_unpaused: got 1 expected 0");
    end
    checks++;
    if (done_count != 1) begin
      errors++;
      $display("[TB] FAIL skip_done: got %0d expected 1", done_count);
    end
    tick_en = 1'b0;

    i_len   = '0;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    step();
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_len0: got busy=%b expected 0", o_busy);
    end

    i_len   = 5'd17;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_len17: got busy=%b expected 0", o_busy);
    end

    i_len   = 5'd2;
    i_start = 1'b1;
    i_stop  = 1'b1;
    step();
    i_start = 1'b0;
    i_stop  = 1'b0;
    step();
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_stop_same: got busy=%b expected 0", o_busy);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;

    start_seq(3, 1'b0);
    wait_play(4'd0, ok);
    i_rst48 = 1'b1;
    step();
    checks++;
    if (!ok || {o_pause, o_busy, o_idx, o_targetf, o_wave} !== {1'b1, 1'b0, 4'd0, 24'd0, 8'd0}) begin
      errors++;
      $display("[TB] FAIL reset_mid: got pause=%b busy=%b idx=%0d f=%0d w=%0d reached=%0d expected 1/0/0/0/0",
               o_pause, o_busy, o_idx, o_targetf, o_wave, ok);
    end
    i_rst48 = 1'b0;
    step();
    start_seq(1, 1'b0);
    repeat (3) step();
    checks++;
    if ({o_pause, o_targetf} !== {1'b0, 24'd1000}) begin
      errors++;
      $display("[TB] FAIL reset_table_kept: got pause=%b f=%0d expected 0/1000", o_pause, o_targetf);
    end
    stop_seq();
    tick_en = 1'b0;
  endtask

  initial begin
    test_reset();
    write_entry(0, 16'd4, 2'd0, 24'd440);
    write_entry(1, 16'd2, 2'd1, 24'd880);
    write_entry(2, 16'd3, 2'd3, 24'd220);
    test_play();
    test_loop();
    test_stop();
    test_edges();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
